// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
package debouncer_pkg;

  // state       | meaning
  // IDLE        | debounced level released, no activity being counted
  // PRESS_CNT   | counting consecutive pressed samples towards a press
  // HELD        | debounced level pressed, auto-repeat timer running
  // RELEASE_CNT | counting consecutive released samples towards a release
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CNT   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CNT = 2'd3
  } state_t;

  // Converts a time in ns into a whole number of clock cycles (truncating).
  function automatic int ns2cycles(input int freq_mhz, input int ns);
    return (freq_mhz * ns) / 1000;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debouncer_channel.sv
// One debounced key: 2-FF synchroniser, glitch counter FSM, auto-repeat timer.
//
// state       | meaning
// IDLE        | released, cnt = 0
// PRESS_CNT   | pressed samples being counted, cnt = run length so far
// HELD        | pressed, rcnt counts towards the next repeat strobe
// RELEASE_CNT | released samples being counted, cnt = run length so far
module debouncer_channel
  import debouncer_pkg::*;
#(
  parameter int N          = 10,
  parameter int D          = 50,
  parameter int P          = 20,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic state_o,
  output logic pressed_stb_o,
  output logic released_stb_o,
  output logic repeat_stb_o
);

  localparam int CW = $clog2(N + 1);
  localparam int RW = $clog2(max2(D, P) + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [RW-1:0] REP_FIRST = RW'(D);
  localparam logic [RW-1:0] REP_NEXT  = RW'(P);
  localparam logic [RW-1:0] RCNT_ONE  = RW'(1);

  logic [1:0]    r_sync;
  logic          w_act;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic [RW-1:0] r_rcnt;
  logic [RW-1:0] w_rcnt_nxt;
  logic [RW-1:0] w_rcnt_inc;
  logic          r_rfirst;
  logic          w_rfirst_nxt;
  logic          w_rep_hit;
  logic          w_level_nxt;
  logic          w_press_nxt;
  logic          w_release_nxt;
  logic          w_repeat_nxt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_repeat;

  // Two-stage synchroniser, reset to the released pin level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= {2{ACTIVE_LOW}};
    end else begin
      r_sync <= {r_sync[0], key_i};
    end
  end

  assign w_act      = r_sync[1] ^ ACTIVE_LOW;
  assign w_cnt_inc  = r_cnt + CNT_ONE;
  assign w_rcnt_inc = r_rcnt + RCNT_ONE;
  // The first repeat waits D cycles, every later one P cycles.
  assign w_rep_hit  = (w_rcnt_inc == (r_rfirst ? REP_FIRST : REP_NEXT));

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rcnt   <= '0;
      r_rfirst <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rcnt   <= w_rcnt_nxt;
      r_rfirst <= w_rfirst_nxt;
    end
  end

  // Next-state and counter update; rcnt only survives while staying in HELD.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rcnt_nxt   = '0;
    w_rfirst_nxt = 1'b1;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_act) begin
          if (N == 1) begin
            w_state_nxt = HELD;
          end else begin
            w_state_nxt = PRESS_CNT;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      PRESS_CNT: begin
        if (!w_act) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      HELD: begin
        if (!w_act) begin
          if (N == 1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = RELEASE_CNT;
            w_cnt_nxt   = CNT_ONE;
          end
        end else begin
          w_cnt_nxt = '0;
          if (REPEAT_EN) begin
            if (w_rep_hit) begin
              w_rcnt_nxt   = '0;
              w_rfirst_nxt = 1'b0;
            end else begin
              w_rcnt_nxt   = w_rcnt_inc;
              w_rfirst_nxt = r_rfirst;
            end
          end
        end
      end
      RELEASE_CNT: begin
        if (w_act) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the transition being taken; registered below.
  always_comb begin
    w_level_nxt   = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_CNT);
    w_press_nxt   = ((r_state == IDLE) || (r_state == PRESS_CNT)) && (w_state_nxt == HELD);
    w_release_nxt = ((r_state == HELD) || (r_state == RELEASE_CNT)) && (w_state_nxt == IDLE);
    w_repeat_nxt  = REPEAT_EN && (r_state == HELD) && w_act && w_rep_hit;
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_repeat  <= w_repeat_nxt;
    end
  end

  assign state_o        = r_level;
  assign pressed_stb_o  = r_press;
  assign released_stb_o = r_release;
  assign repeat_stb_o   = r_repeat;

endmodule

// File: rtl/debouncer_multi.sv
// CHANNELS independent key debouncers with press/release/repeat strobes.
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int CLK_FREQ_MHZ     = 100,
  parameter int GLITCH_TIME_NS   = 100,
  parameter int ACTIVE_LOW       = 1,
  parameter int REPEAT_EN        = 0,
  parameter int REPEAT_DELAY_NS  = 500,
  parameter int REPEAT_PERIOD_NS = 200
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] key_state_o,
  output logic [CHANNELS-1:0] key_pressed_stb_o,
  output logic [CHANNELS-1:0] key_released_stb_o,
  output logic [CHANNELS-1:0] key_repeat_stb_o
);

  localparam int N = ns2cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);
  localparam int D = ns2cycles(CLK_FREQ_MHZ, REPEAT_DELAY_NS);
  localparam int P = ns2cycles(CLK_FREQ_MHZ, REPEAT_PERIOD_NS);
  localparam bit POL_LOW = (ACTIVE_LOW != 0);
  localparam bit REP_ON  = (REPEAT_EN != 0);

  if (N < 1) begin : g_bad_glitch
    $error("debouncer_multi: glitch time shorter than one clock cycle");
  end
  if (D < 1) begin : g_bad_delay
    $error("debouncer_multi: repeat delay shorter than one clock cycle");
  end
  if (P < 1) begin : g_bad_period
    $error("debouncer_multi: repeat period shorter than one clock cycle");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("debouncer_multi: at least one channel required");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debouncer_channel #(
      .N          (N),
      .D          (D),
      .P          (P),
      .ACTIVE_LOW (POL_LOW),
      .REPEAT_EN  (REP_ON)
    ) u_channel (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .key_i          (key_i[g]),
      .state_o        (key_state_o[g]),
      .pressed_stb_o  (key_pressed_stb_o[g]),
      .released_stb_o (key_released_stb_o[g]),
      .repeat_stb_o   (key_repeat_stb_o[g])
    );
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: an active-low build without repeat and an
// active-high build with repeat, both fed the same logical key pattern and
// compared every cycle against a run-length model, plus literal timing pins.
module tb_debouncer_multi;

  localparam int CH = 4;
  localparam int N  = 10;
  localparam int D  = 50;
  localparam int P  = 20;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] p     = '0;
  logic [CH-1:0] key_a, key_b;
  logic [CH-1:0] st_a, pr_a, rl_a, rp_a;
  logic [CH-1:0] st_b, pr_b, rl_b, rp_b;

  assign key_a = ~p;
  assign key_b = p;

  always #5 clk = ~clk;

  debouncer_multi #(.CHANNELS(CH)) u_dut_a (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .key_i              (key_a),
    .key_state_o        (st_a),
    .key_pressed_stb_o  (pr_a),
    .key_released_stb_o (rl_a),
    .key_repeat_stb_o   (rp_a)
  );

  debouncer_multi #(.CHANNELS(CH), .ACTIVE_LOW(0), .REPEAT_EN(1)) u_dut_b (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .key_i              (key_b),
    .key_state_o        (st_b),
    .key_pressed_stb_o  (pr_b),
    .key_released_stb_o (rl_b),
    .key_repeat_stb_o   (rp_b)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    else
      n_pass++;
  endtask

  // Model: the debounced level flips once N consecutive samples (seen two
  // edges late) disagree with it; repeats fire D, D+P, D+2P... edges after
  // the latest edge from which the key has been continuously held.
  logic [CH-1:0] m_d1 = '0, m_d2 = '0;
  logic [CH-1:0] e_state = '0, e_press = '0, e_rel = '0, e_rep = '0;
  int m_run[CH];
  int m_anchor[CH];
  int k = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0;
      e_state = '0; e_press = '0; e_rel = '0; e_rep = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[c] = 0;
        m_anchor[c] = 0;
      end
    end else begin
      k++;
      for (int c = 0; c < CH; c++) begin
        logic a;
        a = m_d2[c];
        e_press[c] = 1'b0;
        e_rel[c]   = 1'b0;
        e_rep[c]   = 1'b0;
        if (a != e_state[c]) begin
          m_run[c]++;
          if (m_run[c] == N) begin
            e_state[c] = a;
            m_run[c] = 0;
            if (a) begin
              e_press[c] = 1'b1;
              m_anchor[c] = k;
            end else begin
              e_rel[c] = 1'b1;
            end
          end
        end else begin
          if (e_state[c] && m_run[c] > 0) m_anchor[c] = k;
          m_run[c] = 0;
          if (e_state[c] && (k - m_anchor[c]) >= D && ((k - m_anchor[c] - D) % P) == 0)
            e_rep[c] = 1'b1;
        end
      end
      m_d2 = m_d1;
      m_d1 = p;
    end
  end

  // Per-cycle comparison of both builds against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("state_a", 32'(st_a), 32'(e_state));
      check("press_a", 32'(pr_a), 32'(e_press));
      check("rel_a",   32'(rl_a), 32'(e_rel));
      check("rep_a",   32'(rp_a), 32'd0);
      check("state_b", 32'(st_b), 32'(e_state));
      check("press_b", 32'(pr_b), 32'(e_press));
      check("rel_b",   32'(rl_b), 32'(e_rel));
      check("rep_b",   32'(rp_b), 32'(e_rep));
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nrep;
    #1 rst_n = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    check("reset_outs_a", 32'({st_a, pr_a, rl_a, rp_a}), 32'd0);
    check("reset_outs_b", 32'({st_b, pr_b, rl_b, rp_b}), 32'd0);
    rst_n = 1'b1;
    cyc(5);

    // Short runs of 8 and 9, then a valid run of 10 with pinned latencies.
    p[0] = 1'b1; cyc(8); p[0] = 1'b0; cyc(1);
    p[0] = 1'b1; cyc(9); p[0] = 1'b0; cyc(1);
    p[0] = 1'b1; cyc(10); p[0] = 1'b0;
    cyc(1);
    check("press10_early", 32'(pr_a), 32'd0);
    cyc(1);
    check("press10_a", 32'(pr_a), 32'h1);
    check("press10_b", 32'(pr_b), 32'h1);
    check("state10_a", 32'(st_a), 32'h1);
    cyc(1);
    check("press10_one_cycle", 32'(pr_a), 32'd0);
    cyc(8);
    check("rel10_early", 32'(rl_a), 32'd0);
    cyc(1);
    check("rel10_a", 32'(rl_a), 32'h1);
    check("rel10_b", 32'(rl_b), 32'h1);
    check("state_after_rel", 32'(st_b), 32'd0);
    cyc(4);
    p[0] = 1'b1; cyc(11); p[0] = 1'b0; cyc(20);

    // Channel 1 held long on the repeat build.
    nrep = 0;
    p[1] = 1'b1;
    for (int i = 1; i <= 211; i++) begin
      cyc(1);
      if (i == 61) check("rep_first_early", 32'(rp_b), 32'd0);
      if (i == 62) check("rep_first", 32'(rp_b), 32'h2);
      if (rp_b[1]) nrep++;
    end
    p[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (rp_b[1]) nrep++;
    end
    check("rep_count", 32'(nrep), 32'd8);

    // Random bounce, mostly released then mostly pressed.
    for (int i = 0; i < 1000; i++) begin
      for (int c = 0; c < CH; c++) p[c] = ($urandom_range(99) >= 90);
      cyc(1);
    end
    for (int i = 0; i < 1000; i++) begin
      for (int c = 0; c < CH; c++) p[c] = ($urandom_range(99) >= 10);
      cyc(1);
    end
    p = '0; cyc(30);

    // Distinct simultaneous patterns per channel.
    for (int i = 0; i < 300; i++) begin
      p[0] = (i < 250);
      p[1] = ((i % 40) < 25);
      p[2] = ((i % 13) != 0);
      p[3] = (i < 40) || (i > 40 && i < 200);
      cyc(1);
    end
    p = '0; cyc(30);

    // Reset during HELD (ch0) and PRESS_CNT (ch1), keys held through it.
    p[0] = 1'b1; cyc(25);
    p[1] = 1'b1; cyc(5);
    check("held_before_rst", 32'(st_a), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", 32'({st_a, pr_a, rl_a, rp_a}), 32'd0);
    check("async_rst_b", 32'({st_b, pr_b, rl_b, rp_b}), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(11);
    check("post_rst_press_early", 32'(pr_a), 32'd0);
    cyc(1);
    check("post_rst_press_a", 32'(pr_a), 32'h3);
    check("post_rst_press_b", 32'(pr_b), 32'h3);
    p = '0; cyc(30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
